// File: rtl/pla_pkg.sv
// Shared types and default sizing for the PLA table engine.
package pla_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_IN_W  = 5;
    localparam int DEF_OUT_W = 14;

endpackage

// File: rtl/pla_table_mem.sv
// Single-write-port table with one registered read port (read-before-write).
module pla_table_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset; the engine's INIT sweep clears it, keeping it mappable to RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // NOTE: non-blocking assignments make a same-edge read see the old word.
    always_ff @(posedge clk) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pla_table_engine.sv
// Programmable lookup table: clears itself after reset, then serves 1-cycle lookups.
// Optional macro PLA_TABLE_PARITY_EN adds per-entry even parity and a parity_err output.
module pla_table_engine
    import pla_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    output logic             cfg_ready,
`ifdef PLA_TABLE_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

`ifdef PLA_TABLE_PARITY_EN
    localparam int MEM_W = OUT_W + 1;
`else
    localparam int MEM_W = OUT_W;
`endif

    localparam logic [IN_W-1:0] CNT_ONE = 1;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              lookup;
    logic              mem_we;
    logic [IN_W-1:0]   mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  cfg_word;
    logic [MEM_W-1:0]  rdata;

`ifdef PLA_TABLE_PARITY_EN
    // Stored parity bit makes the XOR of the whole entry zero.
    assign cfg_word = {^cfg_data, cfg_data};
`else
    assign cfg_word = cfg_data;
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        lookup      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q;
        mem_wdata   = '0;
        case (state_q)
            INIT: begin
                busy        = 1'b1;
                mem_we      = 1'b1;
                cnt_d       = cnt_q + CNT_ONE;
                out_valid_d = 1'b0;
                if (&cnt_q) state_d = RUN;
            end
            RUN: begin
                cfg_ready = 1'b1;
                in_ready  = ~out_valid_q | out_ready;
                lookup    = in_valid & in_ready;
                mem_we    = cfg_we;
                mem_waddr = cfg_addr;
                mem_wdata = cfg_word;
                if (lookup)         out_valid_d = 1'b1;
                else if (out_ready) out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    pla_table_mem #(
        .ADDR_W (IN_W),
        .DATA_W (MEM_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (lookup),
        .raddr_i (in_vec),
        .rdata_o (rdata)
    );

    assign out_valid = out_valid_q;
    assign out_vec   = rdata[OUT_W-1:0];

`ifdef PLA_TABLE_PARITY_EN
    assign parity_err = out_valid_q & (^rdata);
`endif

endmodule

// File: tb/tb_pla_table_engine.sv
// Self-checking bench for pla_table_engine: directed vector table, stall/reset sequences, random vs model.
module tb_pla_table_engine;

    localparam int IN_W  = 5;
    localparam int OUT_W = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_vec;
    logic             cfg_we;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             busy;
`ifdef PLA_TABLE_PARITY_EN
    logic             parity_err;
`endif

    always #5 clk = ~clk;

    pla_table_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
`ifdef PLA_TABLE_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: table contents plus the single pending result.
    logic [OUT_W-1:0] model_tab [2**IN_W];
    logic             m_valid;
    logic [OUT_W-1:0] m_vec;

    typedef struct {
        logic             we;
        logic [IN_W-1:0]  addr;
        logic [OUT_W-1:0] data;
        logic             iv;
        logic [IN_W-1:0]  ivec;
        logic             ordy;
        logic             exp_valid;
        logic [OUT_W-1:0] exp_vec;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2**IN_W; i++) model_tab[i] = '0;
        m_valid = 1'b0;
        m_vec   = '0;
    endtask

    // One RUN-mode cycle: drive, check in_ready, clock, advance model, check result.
    task automatic apply(input logic we, input logic [IN_W-1:0] addr, input logic [OUT_W-1:0] data,
                         input logic iv, input logic [IN_W-1:0] ivec, input logic ordy);
        logic acc;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_data  = data;
        in_valid  = iv;
        in_vec    = ivec;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !m_valid || ordy);
        acc = iv && (!m_valid || ordy);
        tick();
        if (acc) begin
            m_vec   = model_tab[ivec];
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (we) model_tab[addr] = data;
        check("out_valid", out_valid, m_valid);
        if (m_valid) check("out_vec", out_vec, m_vec);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
    endtask

    // Release reset and count INIT cycles, optionally hammering cfg_we meanwhile.
    task automatic wait_init(input logic we_during);
        int n = 0;
        rst_n    = 1'b1;
        cfg_we   = we_during;
        cfg_addr = 5'h03;
        cfg_data = 14'h1555;
        in_valid = 1'b1;
        in_vec   = 5'h03;
        #1;
        check("init_in_ready", in_ready, 1'b0);
        check("init_cfg_ready", cfg_ready, 1'b0);
        while (busy && n < 200) begin
            tick();
            n++;
            if (busy) check("init_out_valid", out_valid, 1'b0);
        end
        check("init_cycles", n, 32);
        idle_inputs();
        #1;
        check("run_cfg_ready", cfg_ready, 1'b1);
        check("run_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'h00, 14'h0001, 1'b0, 5'h00, 1'b1, 1'b0, 14'h0000};
        vecs[1] = '{1'b1, 5'h0B, 14'h0002, 1'b0, 5'h00, 1'b1, 1'b0, 14'h0000};
        vecs[2] = '{1'b0, 5'h00, 14'h0000, 1'b1, 5'h00, 1'b1, 1'b1, 14'h0001};
        vecs[3] = '{1'b0, 5'h00, 14'h0000, 1'b1, 5'h0B, 1'b1, 1'b1, 14'h0002};
        vecs[4] = '{1'b1, 5'h0B, 14'h3FFF, 1'b1, 5'h0B, 1'b1, 1'b1, 14'h0002};
        vecs[5] = '{1'b0, 5'h00, 14'h0000, 1'b1, 5'h0B, 1'b1, 1'b1, 14'h3FFF};
        vecs[6] = '{1'b0, 5'h00, 14'h0000, 1'b0, 5'h00, 1'b1, 1'b0, 14'h0000};

        // Reset state.
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_vec", out_vec, 14'h0000);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b0);
        check("rst_busy", busy, 1'b1);

        // INIT sweep with writes attempted; they must be ignored.
        wait_init(1'b1);
        apply(1'b0, '0, '0, 1'b1, 5'h1F, 1'b1);
        check("lookup_1f", out_vec, 14'h0000);
        apply(1'b0, '0, '0, 1'b1, 5'h03, 1'b1);
        check("init_write_ignored", out_vec, 14'h0000);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].iv, vecs[i].ivec, vecs[i].ordy);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), out_vec, vecs[i].exp_vec);
        end

        // Backpressure: result held, writes to its source entry do not disturb it.
        apply(1'b1, 5'h11, 14'h0002, 1'b0, 5'h00, 1'b1);
        apply(1'b0, 5'h00, 14'h0000, 1'b1, 5'h11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 5'h11, 14'h1234, 1'b1, 5'h00, 1'b0);
            check("stall_out_vec", out_vec, 14'h0002);
            check("stall_out_valid", out_valid, 1'b1);
        end
        apply(1'b0, 5'h00, 14'h0000, 1'b1, 5'h00, 1'b1);
        check("release_accept", out_vec, 14'h0001);
        apply(1'b0, 5'h00, 14'h0000, 1'b1, 5'h11, 1'b1);
        check("stall_write_landed", out_vec, 14'h1234);

        // Reset while a result is pending.
        apply(1'b0, 5'h00, 14'h0000, 1'b1, 5'h0B, 1'b0);
        check("pre_reset_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        model_clear();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b1);
        check("midrst_out_vec", out_vec, 14'h0000);
        wait_init(1'b0);
        apply(1'b0, '0, '0, 1'b1, 5'h00, 1'b1);
        check("cleared_00", out_vec, 14'h0000);
        apply(1'b0, '0, '0, 1'b1, 5'h0B, 1'b1);
        check("cleared_0b", out_vec, 14'h0000);
        apply(1'b0, '0, '0, 1'b1, 5'h11, 1'b1);
        check("cleared_11", out_vec, 14'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 2) == 0,
                  IN_W'($urandom_range(0, 31)),
                  OUT_W'($urandom),
                  $urandom_range(0, 3) != 0,
                  IN_W'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0);
        end

`ifdef PLA_TABLE_PARITY_EN
        // Corrupt one stored bit and expect parity_err with that result only.
        apply(1'b1, 5'h05, 14'h0ABC, 1'b0, 5'h00, 1'b1);
        apply(1'b0, '0, '0, 1'b0, 5'h00, 1'b1);
        dut.u_mem.mem[5] = dut.u_mem.mem[5] ^ 15'h0001;
        model_tab[5] = model_tab[5] ^ 14'h0001;
        apply(1'b0, '0, '0, 1'b1, 5'h05, 1'b1);
        check("parity_err_flip", parity_err, 1'b1);
        apply(1'b1, 5'h06, 14'h0123, 1'b0, 5'h00, 1'b1);
        apply(1'b0, '0, '0, 1'b1, 5'h06, 1'b1);
        check("parity_err_clean", parity_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
